// File: rtl/vram_arb_pkg.sv
// Shared types and default sizes for the VRAM arbiter.
//
// owner_t tags each RAM access with the requester whose read data it returns.
// tag_t travels down the result pipeline alongside each access.
package vram_arb_pkg;

  localparam int unsigned AddrWDefault   = 10;   // 32x32 tile map
  localparam int unsigned DataWDefault   = 8;
  localparam int unsigned MaxWaitDefault = 255;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2
  } owner_t;

  typedef struct packed {
    owner_t owner;  // who receives the result of this access
    logic   rd;     // CPU read: cpu_rdata is loaded on the ack
    logic   miss;   // a video request was displaced by this access
  } tag_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bundle of the video fetch port, CPU/loader port and RAM port of vram_arbiter.
//
// Modports:
//   slave  - the arbiter side (consumes requests and RAM read data).
//   master - the environment side (renderer, CPU and RAM together).
interface vram_arbiter_if
  import vram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned DATA_W = DataWDefault
);

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_data;
  logic              vid_valid;
  logic              vid_miss;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    output vid_data, vid_valid, vid_miss, cpu_rdata, cpu_ack, ram_addr, ram_we, ram_wdata
  );

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    input  vid_data, vid_valid, vid_miss, cpu_rdata, cpu_ack, ram_addr, ram_we, ram_wdata
  );

endinterface

// File: rtl/vram_arb_pipe.sv
// Two-stage owner-tag pipeline that steers RAM read data to the video or CPU side.
//
// Ports:
//   clk, reset    - clock, asynchronous active-low reset.
//   tag_i         - tag of the access being granted at this edge.
//   ram_rdata_i   - RAM read data (one cycle after the address is sampled).
//   vid_data_o    - video read data, held between valids.
//   vid_valid_o   - one pulse per granted video fetch.
//   vid_miss_o    - pulse in the would-be valid cycle of a displaced video fetch.
//   cpu_rdata_o   - CPU read data, updated on read acks only.
//   cpu_ack_o     - one-cycle completion pulse for CPU reads and writes.
//
// Stage 1 covers the cycle the RAM samples the access, stage 2 the cycle the
// read data is on ram_rdata_i; outputs are registered at the end of stage 2.
module vram_arb_pipe
  import vram_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault
) (
  input  logic              clk,
  input  logic              reset,
  input  tag_t              tag_i,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic [DATA_W-1:0] vid_data_o,
  output logic              vid_valid_o,
  output logic              vid_miss_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_ack_o
);

  localparam tag_t TagIdle = '{owner: OWN_NONE, rd: 1'b0, miss: 1'b0};

  tag_t              s1_q, s2_q;
  logic [DATA_W-1:0] vid_data_q, vid_data_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              vid_valid_q, vid_valid_d;
  logic              vid_miss_q, vid_miss_d;
  logic              cpu_ack_q, cpu_ack_d;

  always_comb begin
    vid_data_d  = vid_data_q;
    cpu_rdata_d = cpu_rdata_q;
    vid_valid_d = (s2_q.owner == OWN_VID);
    cpu_ack_d   = (s2_q.owner == OWN_CPU);
    vid_miss_d  = s2_q.miss;
    if (vid_valid_d) begin
      vid_data_d = ram_rdata_i;
    end
    if (cpu_ack_d && s2_q.rd) begin
      cpu_rdata_d = ram_rdata_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q        <= TagIdle;
      s2_q        <= TagIdle;
      vid_data_q  <= '0;
      cpu_rdata_q <= '0;
      vid_valid_q <= 1'b0;
      vid_miss_q  <= 1'b0;
      cpu_ack_q   <= 1'b0;
    end else begin
      s1_q        <= tag_i;
      s2_q        <= s1_q;
      vid_data_q  <= vid_data_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_valid_q <= vid_valid_d;
      vid_miss_q  <= vid_miss_d;
      cpu_ack_q   <= cpu_ack_d;
    end
  end

  assign vid_data_o  = vid_data_q;
  assign vid_valid_o = vid_valid_q;
  assign vid_miss_o  = vid_miss_q;
  assign cpu_rdata_o = cpu_rdata_q;
  assign cpu_ack_o   = cpu_ack_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port tile/video RAM arbiter: video fetch port versus CPU/loader port.
//
// Video has strict priority; the CPU is served on any cycle without a fetch
// through a req/ack handshake. One RAM access per clock, fixed 2-cycle latency
// from the grant edge to vid_valid / cpu_ack.
//
// Ports:
//   clk    - clock, all logic on the rising edge.
//   reset  - asynchronous active-low reset.
//   bus    - vram_arbiter_if.slave: video port, CPU port and RAM port.
//
// Build option ARB_STARVE_GUARD_EN: a wait counter tracks cycles the CPU loses
// to video; once it reaches MAX_WAIT the next contested cycle goes to the CPU
// and the displaced fetch reports vid_miss instead of vid_valid. Without the
// macro, video priority is absolute and vid_miss stays 0.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = AddrWDefault,
  parameter int unsigned DATA_W   = DataWDefault,
  parameter int unsigned MAX_WAIT = MaxWaitDefault
) (
  input logic           clk,
  input logic           reset,
  vram_arbiter_if.slave bus
);

  owner_t            grant;
  logic              grant_miss;
  logic              cpu_ok;
  logic              force_cpu;
  tag_t              grant_tag;

  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              cpu_pend_q, cpu_pend_d;

  logic [DATA_W-1:0] vid_data;
  logic              vid_valid;
  logic              vid_miss;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;

  // cpu_pend blocks re-issue of a held request while its access is in flight.
  assign cpu_ok = bus.cpu_req && !cpu_pend_q;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned WaitW   = ($clog2(MAX_WAIT + 1) > 8) ? $clog2(MAX_WAIT + 1) : 8;
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);

  logic [WaitW-1:0] wait_q, wait_d;

  assign force_cpu = cpu_ok && bus.vid_req && (wait_q == WaitMax);

  always_comb begin
    wait_d = wait_q;
    if (grant == OWN_CPU) begin
      wait_d = '0;
    end else if (cpu_ok && bus.vid_req && (wait_q != WaitMax)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  logic unused_max_wait;

  assign force_cpu       = 1'b0;
  assign unused_max_wait = ^MAX_WAIT;
`endif

  always_comb begin
    grant      = OWN_NONE;
    grant_miss = bus.vid_req && force_cpu;
    if (bus.vid_req && !force_cpu) begin
      grant = OWN_VID;
    end else if (cpu_ok) begin
      grant = OWN_CPU;
    end

    // Address and write data hold on idle cycles; only a CPU write strobes we.
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    unique case (grant)
      OWN_VID: begin
        ram_addr_d = bus.vid_addr;
      end
      OWN_CPU: begin
        ram_addr_d  = bus.cpu_addr;
        ram_we_d    = bus.cpu_we;
        ram_wdata_d = bus.cpu_wdata;
      end
      default: ;
    endcase

    cpu_pend_d = cpu_pend_q;
    if (grant == OWN_CPU) begin
      cpu_pend_d = 1'b1;
    end else if (cpu_ack) begin
      cpu_pend_d = 1'b0;
    end
  end

  assign grant_tag = '{owner: grant, rd: (grant == OWN_CPU) && !bus.cpu_we, miss: grant_miss};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      cpu_pend_q  <= 1'b0;
    end else begin
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      cpu_pend_q  <= cpu_pend_d;
    end
  end

  vram_arb_pipe #(
    .DATA_W (DATA_W)
  ) u_pipe (
    .clk         (clk),
    .reset       (reset),
    .tag_i       (grant_tag),
    .ram_rdata_i (bus.ram_rdata),
    .vid_data_o  (vid_data),
    .vid_valid_o (vid_valid),
    .vid_miss_o  (vid_miss),
    .cpu_rdata_o (cpu_rdata),
    .cpu_ack_o   (cpu_ack)
  );

  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.vid_data  = vid_data;
  assign bus.vid_valid = vid_valid;
  assign bus.vid_miss  = vid_miss;
  assign bus.cpu_rdata = cpu_rdata;
  assign bus.cpu_ack   = cpu_ack;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: synchronous-read RAM model, a shadow
// copy of the expected RAM contents, and scoreboard queues for video data and
// CPU acks that a negedge monitor drains as the DUT produces results.
module tb_vram_arbiter;
  import vram_arb_pkg::*;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  vram_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MAX_WAIT (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW-1:0] mem   [1<<AW];  // RAM model
  logic [DW-1:0] model [1<<AW];  // expected RAM contents

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  logic [DW-1:0] vid_q [$];
  logic [DW:0]   cpu_q [$];  // {is_read, expected rdata}

  int checks = 0;
  int failures = 0;
  int vid_cnt = 0;
  int ack_cnt = 0;
  int we_cnt = 0;
  int miss_cnt = 0;

  // Scoreboard drain.
  always @(negedge clk) begin
    logic [DW-1:0] ev;
    logic [DW:0]   ec;
    if (reset) begin
      if (bus.ram_we) we_cnt++;
      if (bus.vid_miss) miss_cnt++;
      if (bus.vid_valid) begin
        vid_cnt++;
        checks++;
        if (vid_q.size() == 0) begin
          failures++;
          $display("FAIL vid_unexpected: got valid data %h, required no valid", bus.vid_data);
        end else begin
          ev = vid_q.pop_front();
          if (bus.vid_data !== ev) begin
            failures++;
            $display("FAIL vid_data: got %h, required %h", bus.vid_data, ev);
          end
        end
      end
      if (bus.cpu_ack) begin
        ack_cnt++;
        checks++;
        if (cpu_q.size() == 0) begin
          failures++;
          $display("FAIL cpu_ack_unexpected: got ack, required none");
        end else begin
          ec = cpu_q.pop_front();
          if (ec[DW] && (bus.cpu_rdata !== ec[DW-1:0])) begin
            failures++;
            $display("FAIL cpu_rdata: got %h, required %h", bus.cpu_rdata, ec[DW-1:0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.vid_req   = 1'b0;
    bus.vid_addr  = '0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.vid_req   = 1'($urandom);
      bus.vid_addr  = AW'($urandom);
      bus.cpu_req   = 1'($urandom);
      bus.cpu_we    = 1'($urandom);
      bus.cpu_addr  = AW'($urandom);
      bus.cpu_wdata = DW'($urandom);
      tick();
    end
    checks += 8;
    if (bus.vid_data !== '0) begin
      failures++; $display("FAIL rst_vid_data: got %h, required 00", bus.vid_data);
    end
    if (bus.vid_valid !== 1'b0) begin
      failures++; $display("FAIL rst_vid_valid: got %b, required 0", bus.vid_valid);
    end
    if (bus.vid_miss !== 1'b0) begin
      failures++; $display("FAIL rst_vid_miss: got %b, required 0", bus.vid_miss);
    end
    if (bus.cpu_rdata !== '0) begin
      failures++; $display("FAIL rst_cpu_rdata: got %h, required 00", bus.cpu_rdata);
    end
    if (bus.cpu_ack !== 1'b0) begin
      failures++; $display("FAIL rst_cpu_ack: got %b, required 0", bus.cpu_ack);
    end
    if (bus.ram_addr !== '0) begin
      failures++; $display("FAIL rst_ram_addr: got %h, required 000", bus.ram_addr);
    end
    if (bus.ram_we !== 1'b0) begin
      failures++; $display("FAIL rst_ram_we: got %b, required 0", bus.ram_we);
    end
    if (bus.ram_wdata !== '0) begin
      failures++; $display("FAIL rst_ram_wdata: got %h, required 00", bus.ram_wdata);
    end
    idle_inputs();
    tick();
    reset = 1'b1;
    tick();
    // First fetch after reset: valid exactly two edges after the grant edge.
    bus.vid_req  = 1'b1;
    bus.vid_addr = AW'(5);
    vid_q.push_back(model[5]);
    tick();
    bus.vid_req = 1'b0;
    tick();
    checks++;
    if (bus.vid_valid !== 1'b0) begin
      failures++; $display("FAIL rst_first_early: got valid %b, required 0", bus.vid_valid);
    end
    tick();
    checks++;
    if (bus.vid_valid !== 1'b1 || bus.vid_data !== 8'hA7) begin
      failures++;
      $display("FAIL rst_first_fetch: got valid %b data %h, required 1 a7",
               bus.vid_valid, bus.vid_data);
    end
    tick();
  endtask

  task automatic test_stream();
    int first = -1;
    int last = -1;
    int n = 0;
    for (int c = 0; c < 40; c++) begin
      if (c < 32) begin
        bus.vid_req  = 1'b1;
        bus.vid_addr = AW'(c);
        vid_q.push_back(model[c]);
      end else begin
        bus.vid_req = 1'b0;
      end
      tick();
      if (bus.vid_valid) begin
        if (first < 0) first = c;
        last = c;
        n++;
      end
    end
    checks += 3;
    if (n != 32) begin
      failures++; $display("FAIL stream_count: got %0d valids, required 32", n);
    end
    if (last - first + 1 != 32) begin
      failures++; $display("FAIL stream_gaps: got span %0d, required 32", last - first + 1);
    end
    if (first != 2) begin
      failures++; $display("FAIL stream_latency: got first at %0d, required 2", first);
    end
  endtask

  task automatic test_cpu_write_read();
    int we0 = we_cnt;
    int ack0 = ack_cnt;
    int lat;
    bus.vid_req   = 1'b0;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = AW'(10'h100);
    bus.cpu_wdata = 8'h3C;
    model[10'h100] = 8'h3C;
    cpu_q.push_back({1'b0, 8'h00});
    lat = 0;
    do begin tick(); lat++; end while (!bus.cpu_ack && lat < 20);
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    checks++;
    if (lat != 3) begin
      failures++; $display("FAIL wr_ack_latency: got %0d, required 3", lat);
    end
    tick();
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = AW'(10'h100);
    cpu_q.push_back({1'b1, model[10'h100]});
    lat = 0;
    do begin tick(); lat++; end while (!bus.cpu_ack && lat < 20);
    bus.cpu_req = 1'b0;
    checks += 2;
    if (lat != 3) begin
      failures++; $display("FAIL rd_ack_latency: got %0d, required 3", lat);
    end
    if (bus.cpu_rdata !== 8'h3C) begin
      failures++; $display("FAIL rd_data: got %h, required 3c", bus.cpu_rdata);
    end
    for (int i = 0; i < 4; i++) tick();
    checks += 2;
    if (we_cnt - we0 != 1) begin
      failures++; $display("FAIL wr_we_cycles: got %0d, required 1", we_cnt - we0);
    end
    if (ack_cnt - ack0 != 2) begin
      failures++; $display("FAIL wr_rd_acks: got %0d, required 2", ack_cnt - ack0);
    end
  endtask

`ifndef ARB_STARVE_GUARD_EN
  task automatic test_contention();
    int we0 = we_cnt;
    int ack0 = ack_cnt;
    int early = 0;
    int lat;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b1;
    bus.cpu_addr = AW'(10'h020);
    for (int i = 0; i < 10; i++) begin
      bus.vid_req   = 1'b1;
      bus.vid_addr  = AW'(10'h040 + i);
      bus.cpu_wdata = DW'($urandom);  // not yet sampled
      vid_q.push_back(model[10'h040 + i]);
      tick();
      if (bus.cpu_ack) early++;
    end
    bus.vid_req   = 1'b0;
    bus.cpu_wdata = 8'h55;
    model[10'h020] = 8'h55;
    cpu_q.push_back({1'b0, 8'h00});
    lat = 0;
    do begin tick(); lat++; end while (!bus.cpu_ack && lat < 20);
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks += 4;
    if (early != 0) begin
      failures++; $display("FAIL cont_early_ack: got %0d acks, required 0", early);
    end
    if (lat != 3) begin
      failures++; $display("FAIL cont_ack_latency: got %0d, required 3", lat);
    end
    if (ack_cnt - ack0 != 1) begin
      failures++; $display("FAIL cont_acks: got %0d, required 1", ack_cnt - ack0);
    end
    if (we_cnt - we0 != 1) begin
      failures++; $display("FAIL cont_accesses: got %0d writes, required 1", we_cnt - we0);
    end
    // Read back through video to confirm the data sampled at the grant edge.
    bus.vid_req  = 1'b1;
    bus.vid_addr = AW'(10'h020);
    vid_q.push_back(model[10'h020]);
    tick();
    bus.vid_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
  endtask
`else
  task automatic test_guard();
    for (int r = 0; r < 2; r++) begin
      int miss0 = miss_cnt;
      int ack0 = ack_cnt;
      int ack_c = -1;
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = 1'b1;
      bus.cpu_addr  = AW'(10'h030 + r);
      bus.cpu_wdata = DW'(8'h90 + r);
      model[10'h030 + r] = DW'(8'h90 + r);
      cpu_q.push_back({1'b0, 8'h00});
      for (int c = 0; c < 12; c++) begin
        bus.vid_req  = 1'b1;
        bus.vid_addr = AW'(10'h060 + c);
        if (c != 4) vid_q.push_back(model[10'h060 + c]);
        tick();
        if (bus.cpu_ack) begin
          ack_c = c;
          bus.cpu_req = 1'b0;
        end
      end
      bus.vid_req = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      checks += 3;
      if (ack_c != 6) begin
        failures++; $display("FAIL guard_ack_cycle: got %0d, required 6", ack_c);
      end
      if (miss_cnt - miss0 != 1) begin
        failures++; $display("FAIL guard_miss: got %0d, required 1", miss_cnt - miss0);
      end
      if (ack_cnt - ack0 != 1) begin
        failures++; $display("FAIL guard_acks: got %0d, required 1", ack_cnt - ack0);
      end
    end
  endtask
`endif

  task automatic test_reset_mid();
    int ack0 = ack_cnt;
    int lat;
    bus.vid_req  = 1'b0;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = AW'(10'h007);
    tick();  // CPU granted at this edge
    reset = 1'b0;
    bus.cpu_req = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (ack_cnt != ack0) begin
      failures++; $display("FAIL mid_flushed_ack: got %0d acks, required 0", ack_cnt - ack0);
    end
    bus.cpu_req = 1'b1;
    cpu_q.push_back({1'b1, model[10'h007]});
    lat = 0;
    do begin tick(); lat++; end while (!bus.cpu_ack && lat < 20);
    bus.cpu_req = 1'b0;
    checks += 2;
    if (lat != 3) begin
      failures++; $display("FAIL mid_next_latency: got %0d, required 3", lat);
    end
    if (bus.cpu_rdata !== model[10'h007]) begin
      failures++;
      $display("FAIL mid_next_rdata: got %h, required %h", bus.cpu_rdata, model[10'h007]);
    end
    for (int i = 0; i < 4; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]   = DW'(i * 37 + 11);
      model[i] = DW'(i * 37 + 11);
    end
    mem[5]   = 8'hA7;
    model[5] = 8'hA7;
    idle_inputs();

    test_reset();
    test_stream();
    test_cpu_write_read();
`ifndef ARB_STARVE_GUARD_EN
    test_contention();
`else
    test_guard();
`endif
    test_reset_mid();

    checks += 2;
    if (vid_q.size() != 0) begin
      failures++; $display("FAIL vid_outstanding: got %0d left, required 0", vid_q.size());
    end
    if (cpu_q.size() != 0) begin
      failures++; $display("FAIL cpu_outstanding: got %0d left, required 0", cpu_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
